id_ex_decode_stage: RTL

//  Decode stage feeding the ALU: accepts fetched instructions over a valid/ready handshake, decodes the RV32I subset

---
 rtl/id_ex_decode_stage.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_decode_stage.sv
// id_ex_decode_stage
//   Decode stage in front of the ALU. Fetched instructions arrive over a
//   valid/ready handshake. The RV32I subset is decoded into ALU control
//   (alu_signal, func_code, imm) and memory/writeback flags. The result is
//   held in the ID/EX pipeline register.
//   The stage inserts exactly one bubble on a load-use hazard. A branch flush
//   squashes both the held instruction and the incoming one.
//
// Configuration macro: ILLEGAL_TRAP_EN
//   Defined     : unknown opcodes are marked with ex_illegal=1.
//   Not defined : unknown opcodes pass through as a silent NOP, and the
//                 ex_illegal port does not exist.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   if_valid/if_ready fetch handshake
//   if_inst, if_pc    instruction word and its address
//   flush             branch mispredict, kills held and incoming instruction
//   ex_valid/ex_ready ID/EX register handshake towards EX
//   ex_alu_signal     ALU operation class (ALU_NOP..IMM codes)
//   ex_func_code      {inst[30], funct3} for R-type, {1'b0, funct3} otherwise
//   ex_imm            sign-extended immediate
//   ex_pc             pc of the held instruction
//   ex_rs1/ex_rs2     source indices, 0 when the source is unused
//   ex_rd             destination index, 0 when nothing is written back
//   ex_mem_read/ex_mem_write/ex_reg_write/ex_branch   control flags
//   ex_illegal        unknown opcode marker (ILLEGAL_TRAP_EN only)

`ifndef ALU_NOP
`define ALU_NOP     3'd0
`define BINARY      3'd1
`define IMM_BINARY  3'd2
`define BRANCH_COND 3'd3
`define MEM_ADDR    3'd4
`define PC_BASED    3'd5
`define IMM         3'd6
`endif

module id_ex_decode_stage #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_valid,
    output logic           if_ready,
    input  logic [LEN-1:0] if_inst,
    input  logic [LEN-1:0] if_pc,
    input  logic           flush,
    output logic           ex_valid,
    input  logic           ex_ready,
    output logic [2:0]     ex_alu_signal,
    output logic [3:0]     ex_func_code,
    output logic [LEN-1:0] ex_imm,
    output logic [LEN-1:0] ex_pc,
    output logic [4:0]     ex_rs1,
    output logic [4:0]     ex_rs2,
    output logic [4:0]     ex_rd,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic           ex_reg_write,
`ifdef ILLEGAL_TRAP_EN
    output logic           ex_illegal,
`endif
    output logic           ex_branch
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u;

    assign inst   = if_inst[31:0];
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};

    // Decoded view of the incoming instruction
    logic [2:0]  d_alu;
    logic [3:0]  d_func;
    logic [31:0] d_imm32;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        d_mem_read, d_mem_write, d_reg_write, d_branch, d_illegal;

    always_comb begin
        d_alu       = `ALU_NOP;
        d_func      = {1'b0, funct3};
        d_imm32     = '0;
        d_rs1       = '0;
        d_rs2       = '0;
        d_rd        = '0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_reg_write = 1'b0;
        d_branch    = 1'b0;
        d_illegal   = 1'b0;
        unique case (opcode)
            OP_R: begin
                d_alu       = `BINARY;
                d_func      = {inst[30], funct3};
                d_rs1       = inst[19:15];
                d_rs2       = inst[24:20];
                d_rd        = inst[11:7];
                d_reg_write = 1'b1;
            end
            OP_I: begin
                d_alu       = `IMM_BINARY;
                d_imm32     = imm_i;
                d_rs1       = inst[19:15];
                d_rd        = inst[11:7];
                d_reg_write = 1'b1;
            end
            OP_LOAD: begin
                d_alu       = `MEM_ADDR;
                d_imm32     = imm_i;
                d_rs1       = inst[19:15];
                d_rd        = inst[11:7];
                d_mem_read  = 1'b1;
                d_reg_write = 1'b1;
            end
            OP_STORE: begin
                d_alu       = `MEM_ADDR;
                d_imm32     = imm_s;
                d_rs1       = inst[19:15];
                d_rs2       = inst[24:20];
                d_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                d_alu    = `BRANCH_COND;
                d_imm32  = imm_b;
                d_rs1    = inst[19:15];
                d_rs2    = inst[24:20];
                d_branch = 1'b1;
            end
            OP_AUIPC: begin
                d_alu       = `PC_BASED;
                d_imm32     = imm_u;
                d_rd        = inst[11:7];
                d_reg_write = 1'b1;
            end
            OP_LUI: begin
                d_alu       = `IMM;
                d_imm32     = imm_u;
                d_rd        = inst[11:7];
                d_reg_write = 1'b1;
            end
            default: begin
                d_illegal = 1'b1;
            end
        endcase
        // Writes to x0 are dropped here so downstream never sees rd=0 with reg_write=1
        if (d_rd == 5'd0) begin
            d_reg_write = 1'b0;
        end
    end

    // Unused sources decode to index 0, and x0 can never match a nonzero ex_rd,
    // so the plain equality compare already covers the "if used" qualifier.
    logic hz;
    logic advance;

    assign hz = ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                ((d_rs1 == ex_rd) || (d_rs2 == ex_rd));
    assign advance  = !ex_valid || ex_ready;
    assign if_ready = advance && !hz && !flush && !rst;

    logic ill_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid      <= 1'b0;
            ex_alu_signal <= `ALU_NOP;
            ex_func_code  <= '0;
            ex_imm        <= '0;
            ex_pc         <= '0;
            ex_rs1        <= '0;
            ex_rs2        <= '0;
            ex_rd         <= '0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ill_q         <= 1'b0;
        end else if (advance) begin
            if (if_valid && if_ready) begin
                ex_valid      <= 1'b1;
                ex_alu_signal <= d_alu;
                ex_func_code  <= d_func;
                ex_imm        <= LEN'($signed(d_imm32));
                ex_pc         <= if_pc;
                ex_rs1        <= d_rs1;
                ex_rs2        <= d_rs2;
                ex_rd         <= d_rd;
                ex_mem_read   <= d_mem_read;
                ex_mem_write  <= d_mem_write;
                ex_reg_write  <= d_reg_write;
                ex_branch     <= d_branch;
                ill_q         <= d_illegal;
            end else begin
                // Bubble: nothing offered, or a load-use hazard is being resolved
                ex_valid      <= 1'b0;
                ex_alu_signal <= `ALU_NOP;
                ex_func_code  <= '0;
                ex_imm        <= '0;
                ex_pc         <= '0;
                ex_rs1        <= '0;
                ex_rs2        <= '0;
                ex_rd         <= '0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_branch     <= 1'b0;
                ill_q         <= 1'b0;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign ex_illegal = ill_q;
`else
    // Without the trap, an unknown opcode is still held as a valid ALU_NOP
    logic unused_ill;
    assign unused_ill = ill_q;
`endif

endmodule
